// File: rtl/conv_seq_pkg.sv
// Shared types and width helpers for the convolutional layer frame sequencer.
package conv_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int LOG2(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Width of the row/column counters for a given image side.
    function automatic int coord_width(input int image_size);
        return LOG2(image_size);
    endfunction

    // Width of the stride-phase counters for a given stride.
    function automatic int phase_width(input int stride);
        return LOG2(stride);
    endfunction

endpackage

// File: rtl/window_position_tracker.sv
// Row-major pixel position and stride-phase tracking for one frame.
// win_done / last_pixel describe the pixel that would be accepted this cycle.
module window_position_tracker
    import conv_seq_pkg::*;
#(
    parameter int IMAGE_SIZE  = 28,
    parameter int FILTER_SIZE = 3,
    parameter int STRIDE      = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic advance,
    input  logic clear,
    output logic win_done,
    output logic last_pixel
);

    localparam int CW = coord_width(IMAGE_SIZE);
    localparam int PW = phase_width(STRIDE);
    localparam logic [CW-1:0] LAST      = CW'(IMAGE_SIZE - 1);
    localparam logic [CW-1:0] FIRST_WIN = CW'(FILTER_SIZE - 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(STRIDE - 1);

    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic [PW-1:0] col_ph;
    logic [PW-1:0] row_ph;

    // Phase of coordinate coord+1: pinned at 0 until the first full window
    // position, then a wrap-around count so no modulo hardware is needed.
    function automatic logic [PW-1:0] next_phase(input logic [CW-1:0] coord,
                                                 input logic [PW-1:0] ph);
        if (coord < FIRST_WIN) begin
            return '0;
        end else if (ph == PH_LAST) begin
            return '0;
        end else begin
            return ph + 1'b1;
        end
    endfunction

    // Position and phase counters advance once per accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col    <= '0;
            row    <= '0;
            col_ph <= '0;
            row_ph <= '0;
        end else if (clear) begin
            col    <= '0;
            row    <= '0;
            col_ph <= '0;
            row_ph <= '0;
        end else if (advance) begin
            if (col == LAST) begin
                col    <= '0;
                col_ph <= '0;
                if (row == LAST) begin
                    row    <= '0;
                    row_ph <= '0;
                end else begin
                    row    <= row + 1'b1;
                    row_ph <= next_phase(row, row_ph);
                end
            end else begin
                col    <= col + 1'b1;
                col_ph <= next_phase(col, col_ph);
            end
        end
    end

    assign win_done   = (row >= FIRST_WIN) && (col >= FIRST_WIN) &&
                        (row_ph == '0) && (col_ph == '0);
    assign last_pixel = (row == LAST) && (col == LAST);

endmodule

// File: rtl/conv_layer_sequencer.sv
// Frame sequencer feeding a convolutional layer under ready/valid flow control.
// Optional consistency checker enabled by defining CONV_SEQ_CHECK_EN.
module conv_layer_sequencer
    import conv_seq_pkg::*;
#(
    parameter int IMAGE_SIZE  = 28,
    parameter int FILTER_SIZE = 3,
    parameter int STRIDE      = 1,
    parameter int D_WIDTH     = 8,
    parameter int D_CHANNELS  = 1,
    parameter int Q_WIDTH     = 16,
    parameter int Q_CHANNELS  = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [D_WIDTH*D_CHANNELS-1:0]    in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [D_WIDTH*D_CHANNELS-1:0]    layer_in_data,
    output logic                             layer_clk_en,
    input  logic [Q_WIDTH*Q_CHANNELS-1:0]    layer_out_data,
    input  logic                             layer_valid,
    output logic [Q_WIDTH*Q_CHANNELS-1:0]    out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy,
    output logic                             frame_done,
    output logic                             seq_err
);

    seq_state_t state;
    seq_state_t state_next;
    logic       win_pend;
    logic       cap;
    logic       accept;
    logic       win_done;
    logic       last_pixel;
    logic       frame_start;

    // A finished window is taken into the output register whenever that
    // register is empty or being emptied this cycle.
    assign cap          = win_pend && (!out_valid || out_ready);
    assign in_ready     = (state == RUN) && (!win_pend || cap);
    assign accept       = in_valid && in_ready;
    assign layer_clk_en = accept;
    assign layer_in_data = in_data;
    assign busy         = (state != IDLE);
    assign frame_start  = (state == IDLE) && start;

    window_position_tracker #(
        .IMAGE_SIZE (IMAGE_SIZE),
        .FILTER_SIZE(FILTER_SIZE),
        .STRIDE     (STRIDE)
    ) u_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (accept),
        .clear     (frame_start),
        .win_done  (win_done),
        .last_pixel(last_pixel)
    );

    // Next-state decode; frame_done marks the DRAIN to IDLE transition.
    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        case (state)
            IDLE:  if (start) state_next = RUN;
            RUN:   if (accept && last_pixel) state_next = DRAIN;
            DRAIN: begin
                if (!win_pend && !out_valid) begin
                    state_next = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pending-window flag and one-entry output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_pend  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (accept && win_done) begin
                win_pend <= 1'b1;
            end else if (cap) begin
                win_pend <= 1'b0;
            end
            if (cap) begin
                out_valid <= 1'b1;
                out_data  <= layer_out_data;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef CONV_SEQ_CHECK_EN
    localparam int PCW = LOG2(IMAGE_SIZE * IMAGE_SIZE + 1);
    localparam logic [PCW-1:0] PIX_TOTAL = PCW'(IMAGE_SIZE * IMAGE_SIZE);

    logic           acc_d;
    logic [PCW-1:0] pix_cnt;

    // Sticky checker: layer valid must track the window flag one cycle after
    // each acceptance, and each frame must consume exactly one full image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_d   <= 1'b0;
            pix_cnt <= '0;
            seq_err <= 1'b0;
        end else begin
            acc_d <= accept;
            if (frame_start) begin
                pix_cnt <= '0;
            end else if (accept) begin
                pix_cnt <= pix_cnt + 1'b1;
            end
            if (acc_d && (layer_valid != win_pend)) begin
                seq_err <= 1'b1;
            end
            if (frame_done && (pix_cnt != PIX_TOTAL)) begin
                seq_err <= 1'b1;
            end
        end
    end
`else
    logic unused_layer_valid;
    assign unused_layer_valid = layer_valid;
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Self-checking bench: two sequencer instances (4x4 stride 1, 5x5 stride 2)
// driven by directed frames, with a behavioural layer and window scoreboard.
module tb_conv_layer_sequencer;

    localparam int NU = 2;
    localparam int F  = 3;
    localparam int IS_TAB [NU] = '{4, 5};
    localparam int ST_TAB [NU] = '{1, 2};
`ifdef CONV_SEQ_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start [NU];
    logic [7:0]  in_data [NU];
    logic        in_valid [NU];
    logic        in_ready [NU];
    logic [7:0]  layer_in_data [NU];
    logic        layer_clk_en [NU];
    logic [63:0] layer_out_data [NU];
    logic        layer_valid [NU];
    logic [63:0] out_data [NU];
    logic        out_valid [NU];
    logic        out_ready [NU];
    logic        busy [NU];
    logic        frame_done [NU];
    logic        seq_err [NU];
    logic        force_lv [NU];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int salt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NU; gi++) begin : g_dut
        conv_layer_sequencer #(
            .IMAGE_SIZE(IS_TAB[gi]), .FILTER_SIZE(F), .STRIDE(ST_TAB[gi]),
            .D_WIDTH(8), .D_CHANNELS(1), .Q_WIDTH(16), .Q_CHANNELS(4)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start[gi]),
            .in_data(in_data[gi]), .in_valid(in_valid[gi]), .in_ready(in_ready[gi]),
            .layer_in_data(layer_in_data[gi]), .layer_clk_en(layer_clk_en[gi]),
            .layer_out_data(layer_out_data[gi]), .layer_valid(layer_valid[gi]),
            .out_data(out_data[gi]), .out_valid(out_valid[gi]), .out_ready(out_ready[gi]),
            .busy(busy[gi]), .frame_done(frame_done[gi]), .seq_err(seq_err[gi])
        );
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Output vector the layer model produces for a window ending at pixel d.
    function automatic logic [63:0] make_q(input logic [7:0] d);
        return {8'h04, d, 8'h03, d, 8'h02, d, 8'h01, d};
    endfunction

    // Window completes at pixel p when both coordinates sit on the stride grid.
    function automatic bit is_win(input int u, input int p);
        int n, s, r, c;
        n = IS_TAB[u];
        s = ST_TAB[u];
        r = p / n;
        c = p % n;
        return (r >= F - 1) && (c >= F - 1) && ((r - F + 1) % s == 0) && ((c - F + 1) % s == 0);
    endfunction

    // Behavioural layer: state changes only on clk_en.
    logic [63:0] lyr_q [NU];
    logic        lv_q [NU];
    logic        en_s [NU];
    logic        w_s [NU];
    logic [7:0]  d_s [NU];

    always @(posedge clk) begin
        for (int u = 0; u < NU; u++) begin
            if (en_s[u]) begin
                lyr_q[u] <= make_q(d_s[u]);
                lv_q[u]  <= w_s[u];
            end
        end
    end

    always_comb begin
        for (int u = 0; u < NU; u++) begin
            layer_out_data[u] = lyr_q[u];
            layer_valid[u]    = lv_q[u] | force_lv[u];
        end
    end

    // Monitor / scoreboard state.
    int          pix [NU] = '{0, 0};
    int          first_cyc [NU] = '{0, 0};
    int          last_acc_rel [NU] = '{0, 0};
    int          beats [NU] = '{0, 0};
    int          fd_n [NU] = '{0, 0};
    int          fd_rel [NU] = '{0, 0};
    int          en_n [NU] = '{0, 0};
    int          sb_wr [NU] = '{0, 0};
    int          sb_rd [NU] = '{0, 0};
    logic [63:0] sb_mem [NU][64];
    int          ov_log [NU][64];

    // Per-cycle compare against the window model.
    always @(negedge clk) begin
        for (int u = 0; u < NU; u++) begin
            en_s[u] = layer_clk_en[u];
            d_s[u]  = in_data[u];
            if (!rst_n) begin
                sb_rd[u] = sb_wr[u];
                pix[u]   = 0;
                w_s[u]   = 1'b0;
            end else begin
                if (start[u] && !busy[u]) pix[u] = 0;
                w_s[u] = is_win(u, pix[u]);
                chk("clk_en_vs_accept", layer_clk_en[u], in_valid[u] && in_ready[u]);
                if (out_valid[u] && out_ready[u]) begin
                    chk("output_expected", sb_wr[u] != sb_rd[u], 1'b1);
                    if (sb_wr[u] != sb_rd[u]) begin
                        chk("out_data", out_data[u], sb_mem[u][sb_rd[u] % 64]);
                        sb_rd[u]++;
                    end
                    ov_log[u][beats[u] % 64] = cyc - first_cyc[u];
                    beats[u]++;
                end
                if (in_valid[u] && in_ready[u]) begin
                    if (pix[u] == 0) first_cyc[u] = cyc;
                    last_acc_rel[u] = cyc - first_cyc[u];
                    if (w_s[u]) begin
                        sb_mem[u][sb_wr[u] % 64] = make_q(in_data[u]);
                        sb_wr[u]++;
                    end
                    pix[u]++;
                end
                if (layer_clk_en[u]) en_n[u]++;
                if (frame_done[u]) begin
                    fd_n[u]++;
                    fd_rel[u] = cyc - first_cyc[u];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input int u, input int p, input bit gap);
        int t;
        in_valid[u] = 1'b1;
        in_data[u]  = 8'(p + salt);
        t = 0;
        @(negedge clk);
        while (!in_ready[u] && t < 200) begin
            t++;
            @(negedge clk);
        end
        chk("accept_in_time", t < 200, 1'b1);
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
        if (gap) step();
    endtask

    task automatic pulse_start(input int u);
        salt = (salt + 37) % 256;
        start[u] = 1'b1;
        step();
        start[u] = 1'b0;
    endtask

    task automatic wait_done(input int u, input int f0);
        int t;
        t = 0;
        while (fd_n[u] == f0 && t < 100) begin
            step();
            t++;
        end
        chk("frame_done_count", fd_n[u] - f0, 1);
    endtask

    task automatic run_frame(input int u, input bit gap, input int glitch);
        int b0, f0, e0, n;
        b0 = beats[u];
        f0 = fd_n[u];
        e0 = en_n[u];
        n  = IS_TAB[u] * IS_TAB[u];
        pulse_start(u);
        for (int p = 0; p < n; p++) begin
            if (p == glitch) start[u] = 1'b1;
            send_pixel(u, p, gap);
            start[u] = 1'b0;
        end
        wait_done(u, f0);
        chk("out_count", beats[u] - b0, 4);
        chk("clk_en_count", en_n[u] - e0, n);
        chk("sb_drained", sb_wr[u] - sb_rd[u], 0);
        chk("busy_after_done", busy[u], 1'b0);
        chk("seq_err_clean", seq_err[u], 1'b0);
    endtask

    task automatic check_reset_outputs(input int u);
        chk("rst_in_ready", in_ready[u], 1'b0);
        chk("rst_clk_en", layer_clk_en[u], 1'b0);
        chk("rst_out_valid", out_valid[u], 1'b0);
        chk("rst_out_data", out_data[u], 64'h0);
        chk("rst_busy", busy[u], 1'b0);
        chk("rst_frame_done", frame_done[u], 1'b0);
        chk("rst_seq_err", seq_err[u], 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int win0 [4] = '{10, 11, 14, 15};
        int win1 [4] = '{12, 14, 22, 24};
        int ov0 [4]  = '{12, 13, 16, 17};
        int ov1 [4]  = '{14, 16, 24, 26};
        int wl[$];
        int b0, e0, e1, f0;

        for (int u = 0; u < NU; u++) begin
            start[u] = 1'b0; in_valid[u] = 1'b0; in_data[u] = 8'h0;
            out_ready[u] = 1'b1; force_lv[u] = 1'b0;
        end
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs(0);
        check_reset_outputs(1);

        // Pin the window model with hand-derived window positions.
        for (int u = 0; u < NU; u++) begin
            wl.delete();
            for (int p = 0; p < IS_TAB[u] * IS_TAB[u]; p++) if (is_win(u, p)) wl.push_back(p);
            chk("model_win_count", wl.size(), 4);
            for (int i = 0; i < 4 && i < wl.size(); i++)
                chk("model_win_idx", wl[i], (u == 0) ? win0[i] : win1[i]);
        end
        step();
        rst_n = 1'b1;
        step();

        // 4x4 stride 1, back-to-back.
        b0 = beats[0];
        run_frame(0, 1'b0, -1);
        for (int i = 0; i < 4; i++) chk("s1_out_cycle", ov_log[0][(b0 + i) % 64], ov0[i]);
        chk("s1_frame_done_cycle", fd_rel[0], 18);
        chk("s1_last_accept_cycle", last_acc_rel[0], 15);

        // 5x5 stride 2, back-to-back.
        b0 = beats[1];
        run_frame(1, 1'b0, -1);
        for (int i = 0; i < 4; i++) chk("s2_out_cycle", ov_log[1][(b0 + i) % 64], ov1[i]);
        chk("s2_frame_done_cycle", fd_rel[1], 27);
        chk("s2_last_accept_cycle", last_acc_rel[1], 24);

        // Downstream backpressure from pixel 10.
        b0 = beats[0];
        f0 = fd_n[0];
        pulse_start(0);
        for (int p = 0; p < 10; p++) send_pixel(0, p, 1'b0);
        out_ready[0] = 1'b0;
        send_pixel(0, 10, 1'b0);
        send_pixel(0, 11, 1'b0);
        in_valid[0] = 1'b1;
        in_data[0]  = 8'(12 + salt);
        e1 = en_n[0];
        repeat (6) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready[0], 1'b0);
            chk("stall_out_valid", out_valid[0], 1'b1);
            chk("stall_out_data", out_data[0], make_q(8'(10 + salt)));
            @(posedge clk);
            #1;
        end
        chk("stall_no_clk_en", en_n[0] - e1, 0);
        out_ready[0] = 1'b1;
        for (int p = 12; p < 16; p++) send_pixel(0, p, 1'b0);
        wait_done(0, f0);
        chk("stall_out_count", beats[0] - b0, 4);

        // Upstream gaps, then start pulsed mid-frame.
        run_frame(0, 1'b1, -1);
        run_frame(0, 1'b0, 5);

        // Reset in the middle of a frame, then resync and a real frame.
        pulse_start(0);
        for (int p = 0; p < 8; p++) send_pixel(0, p, 1'b0);
        in_valid[0] = 1'b1;
        in_data[0]  = 8'(8 + salt);
        chk("pre_reset_busy", busy[0], 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(0);
        step();
        in_valid[0] = 1'b0;
        rst_n = 1'b1;
        step();
        run_frame(0, 1'b0, -1);
        run_frame(0, 1'b1, -1);

        // Layer valid forced around pixel 3: checker flags it when built in.
        f0 = fd_n[0];
        pulse_start(0);
        for (int p = 0; p < 16; p++) begin
            if (p == 3) force_lv[0] = 1'b1;
            send_pixel(0, p, 1'b0);
            if (p == 4) force_lv[0] = 1'b0;
        end
        wait_done(0, f0);
        chk("seq_err_forced", seq_err[0], CHECK_ON);
        repeat (5) step();
        chk("seq_err_sticky", seq_err[0], CHECK_ON);
        rst_n = 1'b0;
        #1;
        chk("seq_err_reset", seq_err[0], 1'b0);
        step();
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
